// File: rtl/nf10_barrier_sched_if.sv
// nf10_barrier_sched_if
// Groups the barrier request/activity/status signals that run between the
// stimulus/record side of the testbench (master) and the barrier scheduler (slave).
//   activity_stim/rec      per-port activity flags (NUM_PORTS+1 bits, ports plus DMA)
//   activity_trans_sim/log transaction engine activity flags
//   barrier_req            per-port barrier requests (level)
//   barrier_req_trans      transaction engine barrier request (level)
//   barrier_proceed        release to all requesters
//   barrier_timeout        sticky forced-release flag
//   barrier_count          completed barrier count (wraps)
//   sched_state            scheduler state for debug
interface nf10_barrier_sched_if #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned CNT_WIDTH = 16
) ();

   logic [NUM_PORTS:0]   activity_stim;
   logic [NUM_PORTS:0]   activity_rec;
   logic                 activity_trans_sim;
   logic                 activity_trans_log;
   logic [NUM_PORTS:0]   barrier_req;
   logic                 barrier_req_trans;
   logic                 barrier_proceed;
   logic                 barrier_timeout;
   logic [CNT_WIDTH-1:0] barrier_count;
   logic [1:0]           sched_state;

   modport master (
      output activity_stim,
      output activity_rec,
      output activity_trans_sim,
      output activity_trans_log,
      output barrier_req,
      output barrier_req_trans,
      input  barrier_proceed,
      input  barrier_timeout,
      input  barrier_count,
      input  sched_state
   );

   modport slave (
      input  activity_stim,
      input  activity_rec,
      input  activity_trans_sim,
      input  activity_trans_log,
      input  barrier_req,
      input  barrier_req_trans,
      output barrier_proceed,
      output barrier_timeout,
      output barrier_count,
      output sched_state
   );

endinterface

// File: rtl/nf10_barrier_sched.sv
// nf10_barrier_sched
// Simulation barrier sequencer. Waits until every port and the transaction engine
// request a barrier and all activity lines have been quiet for IDLE_CYCLES
// consecutive cycles, then holds barrier_proceed until all requests drop.
// An optional timeout forces the release and sets a sticky flag.
//   axi_aclk     clock
//   axi_aresetn  asynchronous active-low reset
//   bus_io       slave side of nf10_barrier_sched_if (requests/activity in,
//                proceed/timeout/count/state out, all outputs registered)
module nf10_barrier_sched #(
   parameter int unsigned NUM_PORTS      = 4,
   parameter int unsigned IDLE_CYCLES    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                 axi_aclk,
   input  logic                 axi_aresetn,
   nf10_barrier_sched_if.slave  bus_io
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCollect = 2'd1,
      StQuiesce = 2'd2,
      StProceed = 2'd3
   } state_e;

   localparam logic [15:0] IdleLast  = 16'(IDLE_CYCLES - 1);
   localparam logic [31:0] TimerLast = 32'(TIMEOUT_CYCLES - 1);
   localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);

   state_e               state_q, state_d;
   logic [15:0]          idle_cnt_q, idle_cnt_d;
   logic [31:0]          timer_q, timer_d;
   logic                 proceed_q, proceed_d;
   logic                 timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0] count_q, count_d;

   logic all_req, any_req, quiet, timer_hit;

   assign all_req = (&bus_io.barrier_req) & bus_io.barrier_req_trans;
   assign any_req = (|bus_io.barrier_req) | bus_io.barrier_req_trans;
   assign quiet   = ~((|bus_io.activity_stim) | (|bus_io.activity_rec) |
                      bus_io.activity_trans_sim | bus_io.activity_trans_log);

   // Only meaningful while collecting or quiescing; the timer is 0 elsewhere.
   assign timer_hit = TimeoutEn && (timer_q == TimerLast);

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      timeout_d  = timeout_q;
      count_d    = count_q;

      unique case (state_q)
         StIdle: begin
            idle_cnt_d = '0;
            if (any_req) state_d = StCollect;
         end
         StCollect: begin
            idle_cnt_d = '0;
            if (timer_hit) begin
               state_d   = StProceed;
               timeout_d = 1'b1;
            end else if (all_req && quiet) begin
               state_d = StQuiesce;
            end else if (!any_req) begin
               state_d = StIdle;
            end
         end
         StQuiesce: begin
            if (timer_hit) begin
               state_d    = StProceed;
               timeout_d  = 1'b1;
               idle_cnt_d = '0;
            end else if (!all_req) begin
               state_d    = any_req ? StCollect : StIdle;
               idle_cnt_d = '0;
            end else if (!quiet) begin
               // Any activity restarts the full quiet run.
               idle_cnt_d = '0;
            end else if (idle_cnt_q == IdleLast) begin
               state_d    = StProceed;
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 16'd1;
            end
         end
         StProceed: begin
            idle_cnt_d = '0;
            if (!any_req) begin
               state_d = StIdle;
               count_d = count_q + CNT_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Timer runs for the whole COLLECT/QUIESCE episode, including bounces
      // between the two, and is cleared as soon as the barrier leaves them.
      if ((state_d == StCollect || state_d == StQuiesce) &&
          (state_q == StCollect || state_q == StQuiesce)) begin
         timer_d = timer_q + 32'd1;
      end else begin
         timer_d = '0;
      end

      proceed_d = (state_d == StProceed);
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q    <= StIdle;
         idle_cnt_q <= '0;
         timer_q    <= '0;
         proceed_q  <= 1'b0;
         timeout_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         timer_q    <= timer_d;
         proceed_q  <= proceed_d;
         timeout_q  <= timeout_d;
         count_q    <= count_d;
      end
   end

   assign bus_io.barrier_proceed = proceed_q;
   assign bus_io.barrier_timeout = timeout_q;
   assign bus_io.barrier_count   = count_q;
   assign bus_io.sched_state     = state_q;

endmodule

// File: tb/tb_nf10_barrier_sched.sv
// Self-checking bench for nf10_barrier_sched: directed barrier scenarios followed by
// randomized request/activity traffic, all compared every cycle against a
// behavioural model of the barrier rules.
module tb_nf10_barrier_sched;

   localparam int unsigned NP   = 4;
   localparam int unsigned IDLE = 4;
   localparam int unsigned TO   = 20;
   localparam int unsigned CW   = 4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   nf10_barrier_sched_if #(.NUM_PORTS(NP), .CNT_WIDTH(CW)) bus ();

   nf10_barrier_sched #(
      .NUM_PORTS     (NP),
      .IDLE_CYCLES   (IDLE),
      .TIMEOUT_CYCLES(TO),
      .CNT_WIDTH     (CW)
   ) dut (
      .axi_aclk   (clk),
      .axi_aresetn(rstn),
      .bus_io     (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: phase 0 idle, 1 collecting, 2 quiescing, 3 released.
   int    m_phase;
   int    m_quiet_run;
   int    m_timer;
   bit    m_timeout;
   int    m_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase     = 0;
      m_quiet_run = 0;
      m_timer     = 0;
      m_timeout   = 1'b0;
      m_count     = 0;
   endtask

   task automatic model_step();
      bit all_r, any_r, qt, forced;
      int old_phase;
      all_r = (bus.barrier_req == 5'h1F) && bus.barrier_req_trans;
      any_r = (bus.barrier_req != 5'h00) || bus.barrier_req_trans;
      qt    = (bus.activity_stim == 5'h00) && (bus.activity_rec == 5'h00) &&
              !bus.activity_trans_sim && !bus.activity_trans_log;
      old_phase = m_phase;
      forced = (old_phase == 1 || old_phase == 2) && (m_timer + 1 == TO);
      if (forced) begin
         m_phase   = 3;
         m_timeout = 1'b1;
      end else if (old_phase == 0) begin
         if (any_r) m_phase = 1;
      end else if (old_phase == 1) begin
         if (all_r && qt) begin
            m_phase     = 2;
            m_quiet_run = 0;
         end else if (!any_r) begin
            m_phase = 0;
         end
      end else if (old_phase == 2) begin
         if (!all_r) begin
            m_phase = any_r ? 1 : 0;
            m_quiet_run = 0;
         end else if (!qt) begin
            m_quiet_run = 0;
         end else begin
            m_quiet_run++;
            if (m_quiet_run == IDLE) m_phase = 3;
         end
      end else begin
         if (!any_r) begin
            m_phase = 0;
            m_count = (m_count + 1) % (1 << CW);
         end
      end
      if (m_phase != 2) m_quiet_run = 0;
      if ((old_phase == 1 || old_phase == 2) && (m_phase == 1 || m_phase == 2)) m_timer++;
      else m_timer = 0;
   endtask

   task automatic check_all();
      check("sched_state", bus.sched_state, m_phase);
      check("barrier_proceed", bus.barrier_proceed, (m_phase == 3));
      check("barrier_timeout", bus.barrier_timeout, m_timeout);
      check("barrier_count", bus.barrier_count, m_count);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drive(input logic [4:0] req, input logic trans,
                        input logic [4:0] stim, input logic [4:0] rec);
      bus.barrier_req        = req;
      bus.barrier_req_trans  = trans;
      bus.activity_stim      = stim;
      bus.activity_rec       = rec;
      bus.activity_trans_sim = 1'b0;
      bus.activity_trans_log = 1'b0;
   endtask

   initial begin
      logic [4:0] rq;
      logic       rt;
      model_reset();
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      #2;
      check_all();
      rstn = 1'b1;

      // Full barrier from IDLE: proceed 6 edges after requests appear.
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(5);
      check("t1_early", bus.barrier_proceed, 1'b0);
      tick();
      check("t1_proceed", bus.barrier_proceed, 1'b1);
      tick();
      check("t1_held", bus.barrier_proceed, 1'b1);
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      tick();
      check("t1_count", bus.barrier_count, 4'd1);
      check("t1_drop", bus.barrier_proceed, 1'b0);

      // Late requesters: release 5 edges after the last request arrives.
      drive(5'h0F, 1'b0, 5'h00, 5'h00);
      ticks(10);
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(4);
      check("t2_early", bus.barrier_proceed, 1'b0);
      tick();
      check("t2_proceed", bus.barrier_proceed, 1'b1);
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      tick();

      // One-cycle activity pulse restarts the quiet count.
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(5);
      drive(5'h1F, 1'b1, 5'h00, 5'h04);
      tick();
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(3);
      check("t3_early", bus.barrier_proceed, 1'b0);
      tick();
      check("t3_proceed", bus.barrier_proceed, 1'b1);
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      tick();

      // Request drop in QUIESCE falls back to COLLECT.
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(4);
      drive(5'h1D, 1'b1, 5'h00, 5'h00);
      tick();
      check("t4_collect", bus.sched_state, 2'd1);
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(5);
      check("t4_proceed", bus.barrier_proceed, 1'b1);
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      tick();
      check("t4_idle", bus.sched_state, 2'd0);

      // Port 3 never requests: forced release 20 edges after COLLECT entry.
      drive(5'h17, 1'b1, 5'h00, 5'h00);
      tick();
      ticks(19);
      check("t5_early", bus.barrier_proceed, 1'b0);
      tick();
      check("t5_forced", bus.barrier_proceed, 1'b1);
      check("t5_timeout", bus.barrier_timeout, 1'b1);
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      tick();
      check("t5_count", bus.barrier_count, 4'd5);
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(6);
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      tick();
      check("t5_sticky", bus.barrier_timeout, 1'b1);

      // Asynchronous reset while in PROCEED.
      drive(5'h1F, 1'b1, 5'h00, 5'h00);
      ticks(6);
      check("t6_in_proceed", bus.barrier_proceed, 1'b1);
      rstn = 1'b0;
      model_reset();
      #1;
      check_all();
      #1;
      drive(5'h00, 1'b0, 5'h00, 5'h00);
      rstn = 1'b1;

      // Count wraps after 2^CW completed barriers.
      for (int b = 0; b < (1 << CW); b++) begin
         drive(5'h1F, 1'b1, 5'h00, 5'h00);
         ticks(6);
         drive(5'h00, 1'b0, 5'h00, 5'h00);
         tick();
      end
      check("t6_wrap", bus.barrier_count, 4'd0);

      // Randomized traffic.
      rq = 5'h00;
      rt = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (m_phase == 3 && $urandom_range(2) == 0) begin
            rq = 5'h00;
            rt = 1'b0;
         end else begin
            for (int k = 0; k < 5; k++) begin
               if (!rq[k]) rq[k] = ($urandom_range(3) == 0);
               else if ($urandom_range(39) == 0) rq[k] = 1'b0;
            end
            if (!rt) rt = ($urandom_range(3) == 0);
            else if ($urandom_range(39) == 0) rt = 1'b0;
         end
         bus.barrier_req       = rq;
         bus.barrier_req_trans = rt;
         for (int k = 0; k < 5; k++) begin
            bus.activity_stim[k] = ($urandom_range(79) == 0);
            bus.activity_rec[k]  = ($urandom_range(79) == 0);
         end
         bus.activity_trans_sim = ($urandom_range(79) == 0);
         bus.activity_trans_log = ($urandom_range(79) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/nf10_barrier_sched.md
# nf10_barrier_sched

Sequencing controller for the simulation barrier in NetFPGA-10G behavioural testbenches. It collects barrier requests from the NUM_PORTS+1 stimulus/record port pairs and the transaction (register-access) engine. Once every requester has arrived and all activity lines have been quiet for a programmable run of cycles, it releases them with `barrier_proceed`. It also counts completed barriers and flags a barrier that had to be forced open by timeout.

## Interface
- `NUM_PORTS`, 4: number of 10G ports; per-port vectors are NUM_PORTS+1 bits wide (ports plus DMA).
- `IDLE_CYCLES`, 16: consecutive quiet cycles required before release; legal range 1..65535.
- `TIMEOUT_CYCLES`, 0: cycles allowed in COLLECT+QUIESCE before a forced release; 0 disables the timeout; max 2^32-1.
- `CNT_WIDTH`, 16: width of `barrier_count`.

- `axi_aclk` in 1: clock.
- `axi_aresetn` in 1: reset, asynchronous assert, active-low.
- `activity_stim` in NUM_PORTS+1: per-port stimulus-active flags.
- `activity_rec` in NUM_PORTS+1: per-port recorder-active flags.
- `activity_trans_sim` in 1: transaction stimulus active.
- `activity_trans_log` in 1: transaction logger active.
- `barrier_req` in NUM_PORTS+1: per-port barrier request, level, held until proceed is seen.
- `barrier_req_trans` in 1: transaction engine barrier request, level.
- `barrier_proceed` out 1: release, registered.
- `barrier_timeout` out 1: sticky flag, set when any barrier is forced open.
- `barrier_count` out CNT_WIDTH: number of completed barriers, wraps.
- `sched_state` out 2: current FSM state (IDLE=0, COLLECT=1, QUIESCE=2, PROCEED=3), for debug.

## Operation
- Signal definitions:
  - `all_req` = &barrier_req & barrier_req_trans.
  - `any_req` = |barrier_req | barrier_req_trans.
  - `quiet` = ~(|activity_stim | |activity_rec | activity_trans_sim | activity_trans_log).
- IDLE
  - any_req → COLLECT.
  - The timeout timer and idle_cnt are held at 0.
- COLLECT
  - all_req & quiet → QUIESCE, with idle_cnt=0.
  - !any_req → IDLE.
- QUIESCE
  - !all_req → COLLECT (idle_cnt cleared); if !any_req, → IDLE instead.
  - all_req & !quiet → stay in QUIESCE, idle_cnt cleared.
  - all_req & quiet → idle_cnt++; when idle_cnt == IDLE_CYCLES-1, → PROCEED.
  - idle_cnt is 16 bits and never wraps, because it is cleared on exit.
- PROCEED
  - `barrier_proceed`=1.
  - !any_req → IDLE and `barrier_count` increments, wrapping modulo 2^CNT_WIDTH.
  - Activity during PROCEED is ignored.
- Timeout (TIMEOUT_CYCLES≠0)
  - A 32-bit timer increments every cycle in COLLECT or QUIESCE and clears in IDLE/PROCEED.
  - When the timer equals TIMEOUT_CYCLES-1, the next state is PROCEED regardless of all_req/quiet, and `barrier_timeout` is set.
  - Timeout has priority over every other COLLECT/QUIESCE transition.
- `barrier_timeout` clears only on reset.
- A forced barrier still increments `barrier_count` when it exits PROCEED.

## Timing
- Reset values: state=IDLE, `barrier_proceed`=0, `barrier_timeout`=0, `barrier_count`=0, `sched_state`=0, all counters 0.
- Asynchronous reset mid-barrier returns to IDLE immediately; `barrier_proceed` drops without waiting for a clock.
- All outputs are registered and change only on the rising edge of `axi_aclk`. `barrier_proceed` = (state==PROCEED).
- Minimum latency: if all_req & quiet first hold at edge E0 (state COLLECT), QUIESCE is entered at E0 and `barrier_proceed` rises at edge E0+IDLE_CYCLES.
- From IDLE, add one cycle for IDLE→COLLECT.
- Release handshake:
  - `barrier_proceed` stays high until all requests are sampled low.
  - It falls on that same edge, which is also the edge on which `barrier_count` updates.
- Requests re-asserted in the cycle right after PROCEED exit are seen by IDLE on the next edge; no barrier is lost.
- A one-cycle activity pulse in QUIESCE restarts the full IDLE_CYCLES count.

## Test plan
1. NUM_PORTS=4, IDLE_CYCLES=4. Raise all 6 requests together with no activity at edge 0 (IDLE) → COLLECT at edge 1, QUIESCE at edge 2, `barrier_proceed`=1 at edge 6. Drop all requests → `barrier_proceed`=0 and `barrier_count`=1 on the next edge.
2. Ports 0–3 request, port 4 and trans are late by 10 cycles → `barrier_proceed` stays 0 until 5 cycles after the last request (1 cycle COLLECT→QUIESCE + 4 quiet cycles).
3. During QUIESCE, pulse `activity_rec[2]` for one cycle after 3 quiet cycles → idle count restarts; proceed comes 4 quiet cycles after the pulse ends.
4. In QUIESCE, drop `barrier_req[1]` → `sched_state`=1. Re-raise it → full QUIESCE repeats; drop all requests → `sched_state`=0.
5. TIMEOUT_CYCLES=20, port 3 never requests → proceed 20 cycles after COLLECT entry and `barrier_timeout`=1. `barrier_count` increments on release, and `barrier_timeout` stays 1 through the next normal barrier.
6. Assert `axi_aresetn`=0 while in PROCEED with `barrier_count`=0xFFFF (after 65535 barriers; force the count or run long) → all outputs return to reset values asynchronously. Separately, without reset, the 65536th barrier wraps `barrier_count` to 0.
